// File: rtl/canvas_blitter_if.sv
// canvas_blitter_if: command, sprite ROM and canvas write-port bundle.
// master = command issuer / ROM / canvas side; slave = the blitter.
// Ports: start/op/x/y/w/h/colour/sbase command, rom_addr/rom_data sprite ROM,
// waddr/wdata/we canvas write, busy/done status.
interface canvas_blitter_if #(parameter int DW = 15, parameter int SAW = 12);
  logic           start, op;
  logic [7:0]     x, y, w, h;
  logic [11:0]    colour;
  logic [SAW-1:0] sbase, rom_addr;
  logic [11:0]    rom_data;
  logic [DW-1:0]  waddr;
  logic [11:0]    wdata;
  logic           we, busy, done;
  modport master (output start, op, x, y, w, h, colour, sbase, rom_data,
                  input rom_addr, waddr, wdata, we, busy, done);
  modport slave  (input start, op, x, y, w, h, colour, sbase, rom_data,
                  output rom_addr, waddr, wdata, we, busy, done);
endinterface

// File: rtl/canvas_blitter.sv
// canvas_blitter: rectangle fill / keyed sprite copy into the 200x150 canvas RAM, one pixel per cycle.
// Ports: pclk clock, rstn sync active-low reset, bus (slave) carries the
// command, the sprite ROM read port and the canvas write port.
module canvas_blitter #(
  parameter int          DW    = 15,
  parameter int          H_LEN = 200,
  parameter int          V_LEN = 150,
  parameter int          SAW   = 12,
  parameter logic [11:0] KEY   = 12'h0F0
) (
  input logic             pclk,
  input logic             rstn,
  canvas_blitter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, BLIT, DRAIN, FIN} state_t;
  localparam logic [8:0] HL = 9'(H_LEN);
  localparam logic [8:0] VL = 9'(V_LEN);
  state_t         state, state_d;
  logic           lop, we_q, dok, accept, degen, last, ok, row_end;
  logic [7:0]     lx, ly, lw, lh, ci, cj, ni, nj, bx, by, bi, bj;
  logic [11:0]    lcol;
  logic [SAW-1:0] rom_addr;
  logic [DW-1:0]  waddr, dst, dest;
  logic [8:0]     col, row;
  assign accept  = state == IDLE && bus.start;
  assign degen   = bus.w == 8'd0 || bus.h == 8'd0;
  assign row_end = ci == lw - 8'd1;
  assign last    = row_end && cj == lh - 8'd1;
  assign ni      = row_end ? 8'd0 : ci + 8'd1;
  assign nj      = row_end ? cj + 8'd1 : cj;
  // In IDLE the slot being generated is (0,0) of the incoming command, so the
  // first pixel can leave on the accept edge straight from the bus inputs.
  assign bx  = state == IDLE ? bus.x : lx;
  assign by  = state == IDLE ? bus.y : ly;
  assign bi  = state == IDLE ? 8'd0 : ni;
  assign bj  = state == IDLE ? 8'd0 : nj;
  // 9-bit sums so x+i / y+j cannot wrap before the clip test; dest only matters when ok.
  assign col  = {1'b0, bx} + {1'b0, bi};
  assign row  = {1'b0, by} + {1'b0, bj};
  assign ok   = col < HL && row < VL;
  assign dest = DW'(row) * DW'(H_LEN) + DW'(col);
  always_ff @(posedge pclk)
    if (!rstn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = !bus.start ? IDLE : degen ? FIN : bus.op ? BLIT : FILL;
      FILL:    state_d = last ? FIN : FILL;
      BLIT:    state_d = last ? DRAIN : BLIT;
      DRAIN:   state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // Blit pipeline: rom_addr and dst/dok describe slot k; one cycle later the
  // ROM word for slot k arrives while waddr/we_q hold slot k's destination.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      {lop, lx, ly, lw, lh, lcol} <= '0;
      {ci, cj, dok, we_q} <= '0;
      rom_addr <= '0;
      waddr <= '0;
      dst <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        {lop, lx, ly, lw, lh, lcol} <= {bus.op, bus.x, bus.y, bus.w, bus.h, bus.colour};
        ci <= 8'd0;
        cj <= 8'd0;
        if (!degen && !bus.op) begin
          waddr <= dest;
          we_q <= ok;
        end
        if (!degen && bus.op) begin
          rom_addr <= bus.sbase;
          dst <= dest;
          dok <= ok;
        end
      end else if (state == FILL || state == BLIT) begin
        ci <= ni;
        cj <= nj;
        waddr <= state == FILL ? dest : dst;
        we_q <= state == FILL ? ok && !last : dok;
        if (state == BLIT && !last) begin
          rom_addr <= rom_addr + SAW'(1);
          dst <= dest;
          dok <= ok;
        end
      end
    end
  end
  // Sprite data comes straight from the synchronous ROM in its write cycle;
  // only the colour-key gate and the data select sit after the registers.
  assign bus.we       = we_q && !(lop && bus.rom_data == KEY);
  assign bus.wdata    = lop ? bus.rom_data : lcol;
  assign bus.waddr    = waddr;
  assign bus.rom_addr = rom_addr;
  assign bus.busy     = state == FILL || state == BLIT || state == DRAIN;
  assign bus.done     = state == FIN;
endmodule

// File: tb/tb_canvas_blitter.sv
// tb_canvas_blitter: directed vector table plus hand sequences for canvas_blitter.
module tb_canvas_blitter;
  typedef struct {
    logic        op;
    logic [7:0]  x, y, w, h;
    logic [11:0] col, sb;
    int          n, dc, fa, fd, la, ld;
  } vec_t;
  logic pclk = 1'b0, rstn = 1'b0;
  logic [11:0] rom [4096];
  int errors = 0, checks = 0;
  vec_t tbl [10];
  canvas_blitter_if #(.DW(15), .SAW(12)) bus ();
  canvas_blitter dut (.pclk(pclk), .rstn(rstn), .bus(bus));
  always #5 pclk = ~pclk;
  always @(posedge pclk) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.op = v.op; bus.x = v.x; bus.y = v.y; bus.w = v.w; bus.h = v.h;
    bus.colour = v.col; bus.sbase = v.sb;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int wa[$], wd[$];
    int dc;
    logic [11:0] rb;
    bit romchg, inrange;
    @(negedge pclk);
    drive(v);
    bus.start = 1'b1;
    rb = bus.rom_addr;
    @(negedge pclk);
    bus.start = 1'b0;
    dc = -1; romchg = 0; inrange = 1;
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge pclk);
      if (c == 1) chk({tag, " busy_first"}, 32'(bus.busy), 32'(v.w != 0 && v.h != 0));
      if (bus.we) begin
        wa.push_back(32'(bus.waddr));
        wd.push_back(32'(bus.wdata));
        if (bus.waddr >= 15'd30000) inrange = 0;
      end
      if (bus.rom_addr != rb) romchg = 1;
      if (bus.done) begin
        dc = c;
        chk({tag, " busy_at_done"}, 32'(bus.busy), 0);
        break;
      end
    end
    chk({tag, " done_cycle"}, dc, v.dc);
    chk({tag, " write_count"}, wa.size(), v.n);
    chk({tag, " addr_range"}, 32'(inrange), 1);
    chk({tag, " rom_activity"}, 32'(romchg), 32'(v.op && v.w != 0 && v.h != 0));
    if (v.n > 0 && wa.size() > 0) begin
      chk({tag, " first_addr"}, wa[0], v.fa);
      chk({tag, " first_data"}, wd[0], v.fd);
      chk({tag, " last_addr"}, wa[wa.size()-1], v.la);
      chk({tag, " last_data"}, wd[wd.size()-1], v.ld);
    end
    @(negedge pclk);
    chk({tag, " idle_busy"}, 32'(bus.busy), 0);
    chk({tag, " idle_done"}, 32'(bus.done), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " we"}, 32'(bus.we), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " waddr"}, 32'(bus.waddr), 0);
    chk({tag, " wdata"}, 32'(bus.wdata), 0);
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 0);
  endtask

  initial begin
    int n, dones, dc;
    bit romchg, badcol;
    logic [11:0] rb;
    vec_t v;
    for (int i = 0; i < 4096; i++) rom[i] = 12'(i);
    rom[12'h100] = 12'h123; rom[12'h101] = 12'h0F0; rom[12'h102] = 12'h456;
    //        op  x    y    w  h  col     sbase    n dc fa     fd      la     ld
    tbl[0] = '{0, 0,   0,   2, 2, 12'hF00, 12'h000, 4, 5, 0,     'hF00, 201,   'hF00};
    tbl[1] = '{1, 10,  5,   3, 1, 12'h000, 12'h100, 2, 5, 1010,  'h123, 1012,  'h456};
    tbl[2] = '{0, 198, 149, 4, 2, 12'h0AB, 12'h000, 2, 9, 29998, 'h0AB, 29999, 'h0AB};
    tbl[3] = '{0, 5,   5,   0, 7, 12'h111, 12'h000, 0, 1, 0,     0,     0,     0};
    tbl[4] = '{1, 0,   0,   2, 2, 12'h000, 12'h0EF, 3, 6, 0,     'h0EF, 201,   'h0F2};
    tbl[5] = '{1, 199, 0,   2, 2, 12'h000, 12'h010, 2, 6, 199,   'h010, 399,   'h012};
    tbl[6] = '{1, 0,   0,   5, 0, 12'h000, 12'h333, 0, 1, 0,     0,     0,     0};
    tbl[7] = '{1, 3,   2,   3, 1, 12'h000, 12'hFFE, 3, 5, 403,   'hFFE, 405,   'h000};
    tbl[8] = '{0, 199, 149, 1, 1, 12'h777, 12'h000, 1, 2, 29999, 'h777, 29999, 'h777};
    tbl[9] = '{0, 255, 0,   1, 1, 12'h777, 12'h000, 0, 2, 0,     0,     0,     0};
    bus.start = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge pclk);
    chk_reset("reset");
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

    // busy lockout: a blit strobe mid-fill must be ignored entirely
    v = '{0, 20, 20, 4, 4, 12'h555, 12'h000, 16, 17, 4020, 'h555, 4623, 'h555};
    @(negedge pclk);
    drive(v);
    bus.start = 1'b1;
    rb = bus.rom_addr;
    @(negedge pclk);
    bus.start = 1'b0;
    n = 0; dones = 0; dc = -1; romchg = 0; badcol = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge pclk);
      if (c == 3) begin
        bus.op = 1'b1; bus.w = 8'd1; bus.h = 8'd1; bus.sbase = 12'h300; bus.colour = 12'hABC;
        bus.start = 1'b1;
      end
      if (c == 5) bus.start = 1'b0;
      if (bus.we) begin
        n++;
        if (bus.wdata != 12'h555) badcol = 1;
      end
      if (bus.done) begin
        dones++;
        dc = c;
      end
      if (bus.rom_addr != rb) romchg = 1;
    end
    chk("lockout write_count", n, 16);
    chk("lockout done_count", dones, 1);
    chk("lockout done_cycle", dc, 17);
    chk("lockout rom_activity", 32'(romchg), 0);
    chk("lockout fill_colour", 32'(badcol), 0);

    // reset in the middle of an 8x8 blit
    @(negedge pclk);
    drive('{1, 0, 0, 8, 8, 12'h000, 12'h200, 0, 0, 0, 0, 0, 0});
    bus.start = 1'b1;
    @(negedge pclk);
    bus.start = 1'b0;
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge pclk);
      if (bus.we) n++;
      if (n == 5) break;
    end
    chk("midrst writes_before", n, 5);
    rstn = 1'b0;
    @(negedge pclk);
    chk_reset("midrst");
    @(negedge pclk);
    rstn = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      if (bus.we || bus.busy || bus.done) n++;
    end
    chk("midrst quiet_after", n, 0);
    run_cmd(tbl[0], "post_reset_fill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
